// File: rtl/stu_pe_arbiter.sv
// stu_pe_arbiter: per-port FIFOs merged onto one bus by a round-robin, message-atomic arbiter.
// Define STU_PE_ARBITER_SRC_TAG_EN to stamp the granted port index into oob_data[OOB_WIDTH-1 -: 4].
module stu_pe_arbiter #(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int OOB_WIDTH  = 32,
  parameter int TYPE_WIDTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_poweron,
  input  logic [NUM_PE-1:0]                pe__stu__valid,
  input  logic [2*NUM_PE-1:0]              pe__stu__cntl,
  input  logic [TYPE_WIDTH*NUM_PE-1:0]     pe__stu__type,
  input  logic [DATA_WIDTH*NUM_PE-1:0]     pe__stu__data,
  input  logic [OOB_WIDTH*NUM_PE-1:0]      pe__stu__oob_data,
  output logic [NUM_PE-1:0]                stu__pe__ready,
  output logic                             stu__sys__valid,
  output logic [1:0]                       stu__sys__cntl,
  output logic [TYPE_WIDTH-1:0]            stu__sys__type,
  output logic [DATA_WIDTH-1:0]            stu__sys__data,
  output logic [OOB_WIDTH-1:0]             stu__sys__oob_data,
  input  logic                             sys__stu__ready,
  output logic [NUM_PE-1:0]                stu__sys__proto_err
);
  localparam int GW = $clog2(NUM_PE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = 2 + TYPE_WIDTH + DATA_WIDTH + OOB_WIDTH;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [GW-1:0] grant, last_grant, next_grant, idx;
  logic found, xfer;
  logic [NUM_PE-1:0][W-1:0] head;
  logic [NUM_PE-1:0] not_empty, bad, push, pop, drop;
  logic [W-1:0] out_word;
  for (genvar i = 0; i < NUM_PE; i++) begin : g_port
    logic [W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    assign head[i] = mem[rd_ptr];
    assign not_empty[i] = count != '0;
    // A head that does not open a message (MOM/EOM) can never be granted from IDLE
    assign bad[i] = not_empty[i] && !head[i][W-2];
    assign drop[i] = state == IDLE && bad[i];
    assign pop[i] = drop[i] || (xfer && grant == GW'(i));
    assign stu__pe__ready[i] = count != (AW+1)'(FIFO_DEPTH) || pop[i];
    assign push[i] = pe__stu__valid[i] && stu__pe__ready[i];
    always_ff @(posedge clk)
      if (push[i]) mem[wr_ptr] <= {pe__stu__cntl[2*i +: 2], pe__stu__type[TYPE_WIDTH*i +: TYPE_WIDTH],
                                   pe__stu__data[DATA_WIDTH*i +: DATA_WIDTH], pe__stu__oob_data[OOB_WIDTH*i +: OOB_WIDTH]};
    always_ff @(posedge clk or posedge reset_poweron)
      if (reset_poweron) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
  end
  always_comb begin
    found = 1'b0;
    next_grant = last_grant;
    idx = '0;
    for (int k = 1; k <= NUM_PE; k++) begin
      idx = GW'((int'(last_grant) + k) % NUM_PE);
      if (!found && not_empty[idx] && !bad[idx]) begin
        found = 1'b1;
        next_grant = idx;
      end
    end
  end
  assign out_word = head[grant];
  assign stu__sys__valid = state == BUSY && not_empty[grant];
  assign xfer = stu__sys__valid && sys__stu__ready;
  assign stu__sys__cntl = out_word[W-1:W-2];
  assign stu__sys__type = out_word[W-3 -: TYPE_WIDTH];
  assign stu__sys__data = out_word[OOB_WIDTH +: DATA_WIDTH];
`ifdef STU_PE_ARBITER_SRC_TAG_EN
  assign stu__sys__oob_data = {4'(grant), out_word[OOB_WIDTH-5:0]};
`else
  assign stu__sys__oob_data = out_word[OOB_WIDTH-1:0];
`endif
  always_ff @(posedge clk or posedge reset_poweron)
    if (reset_poweron) begin
      state <= IDLE;
      grant <= GW'(NUM_PE-1);
      last_grant <= GW'(NUM_PE-1);
      stu__sys__proto_err <= '0;
    end else begin
      stu__sys__proto_err <= drop;
      if (state == IDLE) begin
        if (found) begin
          state <= BUSY;
          grant <= next_grant;
        end
      end else if (xfer && out_word[W-1]) begin
        state <= IDLE;
        last_grant <= grant;
      end
    end
endmodule
